jk_bank_sequencer: RTL and testbench

JK_BANK_SEQUENCER -- requirements
Module: jk_bank_sequencer

---
 rtl/jk_bank_sequencer.sv | 145 ++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer.sv
// JK flip-flop bank driven by a small command sequencer.
// Commands run for len+1 edges, then a one-cycle done/err.
module jk_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [3:0]       cmd_len,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_SET = 3'b001;
  localparam logic [2:0] OP_CLR = 3'b010;
  localparam logic [2:0] OP_TGL = 3'b011;
  localparam logic [2:0] OP_UP  = 3'b100;
  localparam logic [2:0] OP_DN  = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t           state;
  logic [2:0]       op;
  logic [WIDTH-1:0] mask;
  logic [3:0]       rem;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic             legal;

  assign legal = !(cmd_op[2] && cmd_op[1]);

  // Ripple toggle enables: bit i flips when all lower bits are 1 (up) / 0 (down)
  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & q[i-1];
      dn_t[i] = dn_t[i-1] & ~q[i-1];
    end
  end

  always_comb begin
    j_out = '0;
    k_out = '0;
    if (state == EXEC) begin
      unique case (1'b1)
        (op == OP_SET): j_out = mask;
        (op == OP_CLR): k_out = mask;
        (op == OP_TGL): begin
          j_out = mask;
          k_out = mask;
        end
        (op == OP_UP): begin
          j_out = up_t;
          k_out = up_t;
        end
        (op == OP_DN): begin
          j_out = dn_t;
          k_out = dn_t;
        end
        default: begin
          j_out = '0;
          k_out = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= (j_out & ~q) | (~k_out & q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op        <= OP_NOP;
      mask      <= '0;
      rem       <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op        <= cmd_op;
            mask      <= cmd_mask;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (legal) begin
              state <= EXEC;
              rem   <= cmd_len;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (rem == 4'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            rem <= rem - 4'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed checks for jk_bank_sequencer.
// Outputs are sampled 1 time unit after each rising edge.
module tb_jk_bank_sequencer;

  localparam logic [2:0] OP_SET = 3'b001;
  localparam logic [2:0] OP_CLR = 3'b010;
  localparam logic [2:0] OP_TGL = 3'b011;
  localparam logic [2:0] OP_UP  = 3'b100;
  localparam logic [2:0] OP_DN  = 3'b101;
  localparam logic [2:0] OP_BAD = 3'b110;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [3:0] cmd_len;
  logic [3:0] j_out;
  logic [3:0] k_out;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       err;

  int vectors = 0;
  int miscompares = 0;
  int busy_cnt;

  jk_bank_sequencer #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_len   (cmd_len),
    .j_out     (j_out),
    .k_out     (k_out),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge, then scramble the inputs
  task automatic issue(input logic [2:0] o, input logic [3:0] m,
                       input logic [3:0] l);
    cmd_valid = 1'b1;
    cmd_op    = o;
    cmd_mask  = m;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = OP_BAD;
    cmd_mask  = 4'b1111;
    cmd_len   = 4'hF;
  endtask

  // Single-edge command: check result, done pulse and return to idle
  task automatic one_shot(input string tag, input logic [2:0] o,
                          input logic [3:0] m, input logic [3:0] e);
    issue(o, m, 4'd0);
    tick();
    chk({tag, "_q"}, q, e);
    chk({tag, "_done"}, done, 1);
    tick();
    chk({tag, "_ready"}, cmd_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_mask  = 4'b0000;
    cmd_len   = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 4'b0000);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_jk", {j_out, k_out}, 8'h00);
    rst = 1'b0;

    // SET 0101 len 0
    issue(OP_SET, 4'b0101, 4'd0);
    chk("set_j", j_out, 4'b0101);
    chk("set_k", k_out, 4'b0000);
    chk("set_ready0", cmd_ready, 0);
    tick();
    chk("set_q", q, 4'b0101);
    chk("set_done", done, 1);
    chk("set_busy", busy, 1);
    chk("set_jk_done", {j_out, k_out}, 8'h00);
    tick();
    chk("set_done0", done, 0);
    chk("set_ready", cmd_ready, 1);
    chk("set_busy0", busy, 0);

    one_shot("clr_all", OP_CLR, 4'b1111, 4'b0000);

    // COUNT_UP len 3 from 0000
    busy_cnt = 0;
    issue(OP_UP, 4'b0000, 4'd3);
    busy_cnt += int'(busy);
    tick();
    chk("up_q1", q, 4'b0001);
    busy_cnt += int'(busy);
    tick();
    chk("up_q2", q, 4'b0010);
    busy_cnt += int'(busy);
    tick();
    chk("up_q3", q, 4'b0011);
    chk("up_j3", j_out, 4'b0111);
    chk("up_k3", k_out, 4'b0111);
    chk("up_done_early", done, 0);
    busy_cnt += int'(busy);
    tick();
    chk("up_q4", q, 4'b0100);
    chk("up_done", done, 1);
    busy_cnt += int'(busy);
    tick();
    chk("up_done0", done, 0);
    chk("up_q_hold", q, 4'b0100);
    busy_cnt += int'(busy);
    chk("up_busy_cycles", busy_cnt, 5);

    // COUNT_DOWN 0100 -> 0001
    issue(OP_DN, 4'b1111, 4'd2);
    tick();
    chk("dn_a1", q, 4'b0011);
    tick();
    chk("dn_a2", q, 4'b0010);
    tick();
    chk("dn_a3", q, 4'b0001);
    chk("dn_a_done", done, 1);
    tick();

    // COUNT_DOWN from 0001 with wrap
    issue(OP_DN, 4'b0000, 4'd2);
    chk("dn_j0", j_out, 4'b0001);
    tick();
    chk("dn_b1", q, 4'b0000);
    chk("dn_j_wrap", j_out, 4'b1111);
    tick();
    chk("dn_b2", q, 4'b1111);
    tick();
    chk("dn_b3", q, 4'b1110);
    chk("dn_b_done", done, 1);
    tick();

    one_shot("clr_bit1", OP_CLR, 4'b0010, 4'b1100);

    // TOGGLE 1010 len 1 from 1100
    issue(OP_TGL, 4'b1010, 4'd1);
    tick();
    chk("tgl_q1", q, 4'b0110);
    chk("tgl_done_early", done, 0);
    tick();
    chk("tgl_q2", q, 4'b1100);
    chk("tgl_done", done, 1);
    tick();

    // Illegal op: no bank change, done+err together for one cycle
    issue(OP_BAD, 4'b1111, 4'd5);
    chk("bad_q", q, 4'b1100);
    chk("bad_done", done, 1);
    chk("bad_err", err, 1);
    chk("bad_busy", busy, 1);
    chk("bad_jk", {j_out, k_out}, 8'h00);
    tick();
    chk("bad_q_after", q, 4'b1100);
    chk("bad_done0", done, 0);
    chk("bad_err0", err, 0);
    chk("bad_ready", cmd_ready, 1);

    one_shot("clr_final", OP_CLR, 4'b1111, 4'b0000);

    // Reset mid COUNT_UP len 15
    issue(OP_UP, 4'b0000, 4'd15);
    repeat (5) tick();
    chk("abort_q5", q, 4'b0101);
    chk("abort_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_q0", q, 4'b0000);
    chk("abort_done", done, 0);
    chk("abort_busy0", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = OP_SET;
    cmd_mask  = 4'b1001;
    cmd_len   = 4'd0;
    #2;
    rst = 1'b0;
    tick();
    cmd_valid = 1'b0;
    chk("post_accept_busy", busy, 1);
    chk("post_accept_done", done, 0);
    tick();
    chk("post_q", q, 4'b1001);
    chk("post_done", done, 1);
    tick();
    chk("post_ready", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
